// File: rtl/parser_slice_buffer.sv
// Per-parser FWFT slice buffer. It holds slices granted by the distributor until
// the parser pops them, and reports free space back to the distributor as `ready`.
module parser_slice_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [143:0]     data_in,
  input  logic [15:0]      position_in,
  input  logic [16:0]      address_in,
  input  logic [2:0]       garbage_in,
  input  logic             lit_flag_in,
  output logic             ready,
  input  logic             flush,
  input  logic             rd_en,
  output logic             valid_out,
  output logic [143:0]     data_out,
  output logic [15:0]      position_out,
  output logic [16:0]      address_out,
  output logic [2:0]       garbage_out,
  output logic             lit_flag_out,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow,
  output logic [15:0]      slices_in
);

  typedef struct packed {
    logic [143:0] data;
    logic [15:0]  position;
    logic [16:0]  address;
    logic [2:0]   garbage;
    logic         lit_flag;
  } slice_t;

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  slice_t           mem_q [DEPTH];
  slice_t           wr_slice, head;
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [15:0]      sin_q, sin_d;
  logic             push_ok, pop_ok, push_rej, pop_rej;

  // ready/valid_out decode registered occupancy only: the distributor consumes
  // ready combinationally, so no path from valid_in/rd_en/flush is allowed.
  assign ready     = (cnt_q != FULL);
  assign valid_out = (cnt_q != '0);

  assign push_ok  = valid_in &  ready     & ~flush;
  assign push_rej = valid_in & ~ready     & ~flush;
  assign pop_ok   = rd_en    &  valid_out & ~flush;
  assign pop_rej  = rd_en    & ~valid_out & ~flush;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | push_rej;
    unf_d = unf_q | pop_rej;
    sin_d = sin_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        wp_d  = wp_q + PTR_ONE;
        sin_d = sin_q + 16'd1;
      end
      if (pop_ok) rp_d = rp_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      sin_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      sin_q <= sin_d;
    end
  end

  // Storage is deliberately left unreset; valid_out qualifies the head fields.
  assign wr_slice = '{data: data_in, position: position_in, address: address_in,
                      garbage: garbage_in, lit_flag: lit_flag_in};

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wp_q] <= wr_slice;
  end

  assign head         = mem_q[rp_q];
  assign data_out     = head.data;
  assign position_out = head.position;
  assign address_out  = head.address;
  assign garbage_out  = head.garbage;
  assign lit_flag_out = head.lit_flag;

  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign slices_in = sin_q;

endmodule
